// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_pkg : shared widths for the 16-bit to 256-bit packing FIFO          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package fifo_pkg;
  localparam int WR_WIDTH = 16;
  localparam int RD_WIDTH = 256;
  localparam int RATIO    = RD_WIDTH / WR_WIDTH;
  localparam int RD_DEPTH = 128;
  localparam int WR_DEPTH = RD_DEPTH * RATIO;
  localparam int LANE_W   = $clog2(RATIO);
  localparam int RD_PTR_W = $clog2(RD_DEPTH);
  localparam int WR_PTR_W = $clog2(WR_DEPTH);
  localparam int CNT_W    = WR_PTR_W + 1;
  localparam int RD_LVL_W = RD_PTR_W + 1;
endpackage
`default_nettype wire

// File: rtl/sdp_ram_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdp_ram_lane : 128x256 simple dual-port RAM, per-lane write enables,     |
// |                registered read port that holds between reads             |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module sdp_ram_lane
  import fifo_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [RATIO-1:0]    wr_lane_en,
  input  logic [RD_PTR_W-1:0] wr_addr,
  input  logic [RD_WIDTH-1:0] wr_data,
  input  logic                rd_en,
  input  logic [RD_PTR_W-1:0] rd_addr,
  output logic [RD_WIDTH-1:0] rd_data
);

  logic [RD_WIDTH-1:0] mem [RD_DEPTH];
  logic [RD_WIDTH-1:0] rd_data_d;
  logic [RD_WIDTH-1:0] rd_data_q;

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int l = 0; l < RATIO; l++) begin
      if (wr_lane_en[l]) begin
        mem[wr_addr][l*WR_WIDTH +: WR_WIDTH] <= wr_data[l*WR_WIDTH +: WR_WIDTH];
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/fifo_16i_256o.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_16i_256o : single-clock FIFO packing 16 pixel words per 256-bit beat|
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module fifo_16i_256o
  import fifo_pkg::*;
#(
  parameter int AF_LEVEL = 2032,
  parameter int AE_LEVEL = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [WR_WIDTH-1:0] wr_data,
  output logic                wr_full,
  output logic [CNT_W-1:0]    wr_water_level,
  output logic                almost_full,
  input  logic                rd_en,
  output logic [RD_WIDTH-1:0] rd_data,
  output logic                rd_empty,
  output logic [RD_LVL_W-1:0] rd_water_level,
  output logic                almost_empty
);

  logic [WR_PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [RD_PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic                wr_ok, rd_ok;
  logic [RATIO-1:0]    lane_en;

  assign wr_full        = (cnt_q == CNT_W'(WR_DEPTH));
  assign rd_empty       = (cnt_q < CNT_W'(RATIO));
  assign wr_water_level = cnt_q;
  assign rd_water_level = cnt_q[CNT_W-1:LANE_W];
  assign almost_full    = (cnt_q >= CNT_W'(AF_LEVEL));
  assign almost_empty   = (rd_water_level <= RD_LVL_W'(AE_LEVEL));

  // Both qualifiers use pre-edge flags, so a same-cycle write never enables a read.
  assign wr_ok = wr_en && !wr_full;
  assign rd_ok = rd_en && !rd_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - CNT_W'(RATIO);
      2'b11:   cnt_d = cnt_q - CNT_W'(RATIO - 1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Low pointer bits pick the 16-bit lane inside the current row.
  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    assign lane_en[i] = wr_ok && (wr_ptr_q[LANE_W-1:0] == LANE_W'(i));
  end

  sdp_ram_lane u_ram (
    .clk        (clk),
    .rst        (rst),
    .wr_lane_en (lane_en),
    .wr_addr    (wr_ptr_q[WR_PTR_W-1:LANE_W]),
    .wr_data    ({RATIO{wr_data}}),
    .rd_en      (rd_ok),
    .rd_addr    (rd_ptr_q),
    .rd_data    (rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_16i_256o.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_16i_256o : directed self-checking bench for fifo_16i_256o        |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_fifo_16i_256o;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [15:0]  wr_data;
  logic         wr_full;
  logic [11:0]  wr_water_level;
  logic         almost_full;
  logic         rd_en;
  logic [255:0] rd_data;
  logic         rd_empty;
  logic [7:0]   rd_water_level;
  logic         almost_empty;

  int           total = 0;
  int           bad   = 0;
  int           exp_cnt = 0;
  logic [15:0]  q[$];
  logic [255:0] exp_rd = '0;
  logic [15:0]  seq = 16'h1000;

  always #5 clk = ~clk;

  fifo_16i_256o dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty)
  );

  // One clock with the given inputs; a queue of written words supplies expected rows.
  task automatic cycle(input logic we, input logic [15:0] wd, input logic re);
    bit wr_ok, rd_ok;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    wr_ok   = we && (exp_cnt != 2048);
    rd_ok   = re && (exp_cnt >= 16);
    @(posedge clk);
    #1;
    if (rd_ok) for (int k = 0; k < 16; k++) exp_rd[16*k +: 16] = q.pop_front();
    if (wr_ok) q.push_back(wd);
    exp_cnt = exp_cnt + (wr_ok ? 1 : 0) - (rd_ok ? 16 : 0);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    exp_cnt = 0;
    q.delete();
    exp_rd = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (wr_water_level !== 12'd0) begin bad++; $display("FAIL reset_wr_level got=%0d want=0", wr_water_level); end
    total++; if (rd_water_level !== 8'd0) begin bad++; $display("FAIL reset_rd_level got=%0d want=0", rd_water_level); end
    total++; if ({rd_empty, almost_empty, wr_full, almost_full} !== 4'b1100) begin bad++; $display("FAIL reset_flags got=%b want=1100", {rd_empty, almost_empty, wr_full, almost_full}); end
    total++; if (rd_data !== 256'd0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
  endtask

  task automatic test_single_row();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 16'(i), 1'b0);
      if (i == 14) begin
        total++; if ({rd_water_level, rd_empty} !== {8'd0, 1'b1}) begin bad++; $display("FAIL row15_level got=%0d/%b want=0/1", rd_water_level, rd_empty); end
      end
    end
    total++; if ({rd_water_level, rd_empty} !== {8'd1, 1'b0}) begin bad++; $display("FAIL row16_level got=%0d/%b want=1/0", rd_water_level, rd_empty); end
    cycle(1'b0, 16'h0, 1'b1);
    total++; if (rd_data !== 256'h000f000e000d000c000b000a0009000800070006000500040003000200010000) begin bad++; $display("FAIL row_pack got=%h", rd_data); end
    total++; if ({rd_empty, rd_water_level} !== {1'b1, 8'd0}) begin bad++; $display("FAIL row_after_read got=%b/%0d want=1/0", rd_empty, rd_water_level); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 640; i++) begin
      cycle(1'b1, seq, 1'b0);
      seq = seq + 16'h0123;
    end
    total++; if (rd_water_level !== 8'd40) begin bad++; $display("FAIL b2b_rd_level got=%0d want=40", rd_water_level); end
    total++; if (wr_water_level !== 12'd640) begin bad++; $display("FAIL b2b_wr_level got=%0d want=640", wr_water_level); end
    for (int r = 0; r < 40; r++) begin
      cycle(1'b0, 16'h0, 1'b1);
      total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL b2b_row%0d got=%h want=%h", r, rd_data, exp_rd); end
    end
    total++; if ({wr_water_level, rd_water_level, rd_empty} !== {12'd0, 8'd0, 1'b1}) begin bad++; $display("FAIL b2b_drained got=%0d/%0d/%b want=0/0/1", wr_water_level, rd_water_level, rd_empty); end
  endtask

  task automatic test_partial();
    logic [255:0] prev;
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, seq, 1'b0);
      seq = seq + 16'h0123;
    end
    total++; if ({rd_empty, rd_water_level, wr_water_level} !== {1'b1, 8'd0, 12'd15}) begin bad++; $display("FAIL partial_levels got=%b/%0d/%0d want=1/0/15", rd_empty, rd_water_level, wr_water_level); end
    prev = rd_data;
    cycle(1'b0, 16'h0, 1'b1);
    total++; if (rd_data !== prev) begin bad++; $display("FAIL partial_read_ignored got=%h want=%h", rd_data, prev); end
    total++; if (wr_water_level !== 12'd15) begin bad++; $display("FAIL partial_cnt got=%0d want=15", wr_water_level); end
  endtask

  task automatic test_same_cycle();
    cycle(1'b1, seq, 1'b0);
    seq = seq + 16'h0123;
    total++; if ({rd_empty, wr_water_level} !== {1'b0, 12'd16}) begin bad++; $display("FAIL sim_pre got=%b/%0d want=0/16", rd_empty, wr_water_level); end
    cycle(1'b1, seq, 1'b1);
    seq = seq + 16'h0123;
    total++; if ({rd_empty, wr_water_level} !== {1'b1, 12'd1}) begin bad++; $display("FAIL sim_cnt got=%b/%0d want=1/1", rd_empty, wr_water_level); end
    total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL sim_row got=%h want=%h", rd_data, exp_rd); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 2030; i++) begin
      cycle(1'b1, seq, 1'b0);
      seq = seq + 16'h0123;
    end
    total++; if ({almost_full, wr_water_level} !== {1'b0, 12'd2031}) begin bad++; $display("FAIL af_2031 got=%b/%0d want=0/2031", almost_full, wr_water_level); end
    cycle(1'b1, seq, 1'b0);
    seq = seq + 16'h0123;
    total++; if ({almost_full, wr_full} !== 2'b10) begin bad++; $display("FAIL af_2032 got=%b%b want=10", almost_full, wr_full); end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, seq, 1'b0);
      seq = seq + 16'h0123;
    end
    total++; if ({wr_full, wr_water_level, rd_water_level} !== {1'b1, 12'd2048, 8'd128}) begin bad++; $display("FAIL full got=%b/%0d/%0d want=1/2048/128", wr_full, wr_water_level, rd_water_level); end
    cycle(1'b1, 16'hDEAD, 1'b0);
    total++; if ({wr_full, wr_water_level} !== {1'b1, 12'd2048}) begin bad++; $display("FAIL drop_2049 got=%b/%0d want=1/2048", wr_full, wr_water_level); end
    for (int r = 0; r < 128; r++) begin
      cycle(1'b0, 16'h0, 1'b1);
      total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL wrap_row%0d got=%h want=%h", r, rd_data, exp_rd); end
      if (r == 125) begin
        total++; if ({rd_water_level, almost_empty} !== {8'd2, 1'b0}) begin bad++; $display("FAIL ae_level2 got=%0d/%b want=2/0", rd_water_level, almost_empty); end
      end
      if (r == 126) begin
        total++; if ({rd_water_level, almost_empty} !== {8'd1, 1'b1}) begin bad++; $display("FAIL ae_level1 got=%0d/%b want=1/1", rd_water_level, almost_empty); end
      end
    end
    total++; if ({wr_water_level, rd_empty, wr_full} !== {12'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL wrap_drained got=%0d/%b/%b want=0/1/0", wr_water_level, rd_empty, wr_full); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, seq, 1'b0);
      seq = seq + 16'h0123;
    end
    cycle(1'b0, 16'h0, 1'b1);
    total++; if ({wr_water_level, rd_water_level} !== {12'd284, 8'd17}) begin bad++; $display("FAIL pre_rst got=%0d/%0d want=284/17", wr_water_level, rd_water_level); end
    apply_reset();
    total++; if ({wr_water_level, rd_water_level, rd_empty, almost_full} !== {12'd0, 8'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL mid_rst_levels got=%0d/%0d/%b/%b want=0/0/1/0", wr_water_level, rd_water_level, rd_empty, almost_full); end
    total++; if (rd_data !== 256'd0) begin bad++; $display("FAIL mid_rst_data got=%h want=0", rd_data); end
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'hA000 + 16'(i), 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    total++; if (rd_data[31:0] !== 32'hA001_A000) begin bad++; $display("FAIL mid_rst_lane0 got=%h want=a001a000", rd_data[31:0]); end
    total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL mid_rst_row got=%h want=%h", rd_data, exp_rd); end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 16'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_row();
    test_back_to_back();
    test_partial();
    test_same_cycle();
    test_full_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
